// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: checkpoints agreed register/PC commits
// and replays them into both cores after a comparator mismatch.
module ft_recovery_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 32,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR = 32'h0000_0080,
  parameter int HALT_TIMEOUT = 64,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_instr_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  error_i,
  input  logic                  halted_a_i,
  input  logic                  halted_b_i,
  output logic                  halt_o,
  output logic                  rec_we_o,
  output logic [ADDR_WIDTH-1:0] rec_addr_o,
  output logic [DATA_WIDTH-1:0] rec_data_o,
  output logic                  pc_we_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  recovering_o,
  output logic                  recovery_done_o,
  output logic                  fatal_o,
  output logic [CNT_WIDTH-1:0]  err_count_o
);

  localparam int TW = $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_RESTORE,
    S_PC_RESTORE,
    S_RESUME,
    S_FATAL
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ckpt_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] ckpt_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] ckpt_pc_q, ckpt_pc_d;
  logic                  ack_a_q, ack_a_d;
  logic                  ack_b_q, ack_b_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    ckpt_d    = ckpt_q;
    ckpt_pc_d = ckpt_pc_q;
    ack_a_d   = ack_a_q;
    ack_b_d   = ack_b_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid_instr_i && error_i) begin
          state_d = S_HALT;
          tmo_d   = '0;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (valid_instr_i) begin
          ckpt_pc_d = pc_i;
          // x0 is hardwired; out-of-range indices match no slot
          for (int i = 1; i < NUM_REGS; i++) begin
            if (we_i && addr_i == ADDR_WIDTH'(i)) ckpt_d[i] = data_i;
          end
        end
      end
      S_HALT: begin
        ack_a_d = ack_a_q | halted_a_i;
        ack_b_d = ack_b_q | halted_b_i;
        if (ack_a_d && ack_b_d) begin
          state_d = S_RESTORE;
          idx_d   = '0;
        end else if (tmo_q == TW'(HALT_TIMEOUT - 1)) begin
          state_d = S_FATAL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESTORE: begin
        if (idx_q == ADDR_WIDTH'(NUM_REGS - 1)) state_d = S_PC_RESTORE;
        else idx_d = idx_q + 1'b1;
      end
      S_PC_RESTORE: state_d = S_RESUME;
      S_RESUME: begin
        state_d = S_IDLE;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        idx_d   = '0;
        tmo_d   = '0;
      end
      S_FATAL: state_d = S_FATAL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < NUM_REGS; i++) ckpt_q[i] <= '0;
      ckpt_pc_q <= BOOT_ADDR;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      idx_q     <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ckpt_q    <= ckpt_d;
      ckpt_pc_q <= ckpt_pc_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign halt_o = (state_q == S_HALT) || (state_q == S_RESTORE) ||
                  (state_q == S_PC_RESTORE) || (state_q == S_FATAL);
  assign rec_we_o        = (state_q == S_RESTORE);
  assign rec_addr_o      = rec_we_o ? idx_q : '0;
  assign rec_data_o      = rec_we_o ? ckpt_q[idx_q] : '0;
  assign pc_we_o         = (state_q == S_PC_RESTORE);
  assign pc_o            = ckpt_pc_q;
  assign recovering_o    = (state_q != S_IDLE);
  assign recovery_done_o = (state_q == S_RESUME);
  assign fatal_o         = (state_q == S_FATAL);
  assign err_count_o     = cnt_q;

endmodule
